// File: rtl/rv_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// rv_ctrl_pkg
// Shared definitions for the control sequencer: RV32 major-opcode constants,
// the active-low unit-enable encoding, the sequencer state enum and a small
// helper that turns a boolean request into an active-low enable level.
// ----------------------------------------------------------------------------
package rv_ctrl_pkg;

    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_ALU_IMM = 7'b0010011;
    localparam logic [6:0] OP_ALU_REG = 7'b0110011;
    localparam logic [6:0] OP_FENCE   = 7'b0001111;
    localparam logic [6:0] OP_SYS     = 7'b1110011;

    // Unit enables are active-low.
    localparam logic ENABLED  = 1'b0;
    localparam logic DISABLED = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        EXECUTE,
        MEM_WAIT,
        WRITEBACK,
        TRAP
    } state_t;

    function automatic logic enable_if(input logic cond);
        return cond ? ENABLED : DISABLED;
    endfunction

endpackage

// File: rtl/opcode_class_decode.sv
// ----------------------------------------------------------------------------
// opcode_class_decode
// Purely combinational classification of an opcode.
// Ports:
//   opcode    in  OPCODE_LEN  opcode to classify
//   legal     out 1  opcode is one of the supported major opcodes
//   uses_alu  out 1  instruction needs the ALU in EXECUTE
//   is_branch out 1  conditional branch
//   is_load   out 1  memory load
//   is_store  out 1  memory store
//   writes_rd out 1  instruction writes the register array in WRITEBACK
// ----------------------------------------------------------------------------
module opcode_class_decode
    import rv_ctrl_pkg::*;
#(
    parameter int OPCODE_LEN = 7
) (
    input  logic [OPCODE_LEN-1:0] opcode,
    output logic                  legal,
    output logic                  uses_alu,
    output logic                  is_branch,
    output logic                  is_load,
    output logic                  is_store,
    output logic                  writes_rd
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        legal     = 1'b1;
        uses_alu  = 1'b0;
        is_branch = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        writes_rd = 1'b0;
        case (opcode)
            OPCODE_LEN'(OP_LUI):     writes_rd = 1'b1;
            OPCODE_LEN'(OP_AUIPC):   begin uses_alu = 1'b1; writes_rd = 1'b1; end
            OPCODE_LEN'(OP_JAL):     begin uses_alu = 1'b1; writes_rd = 1'b1; end
            OPCODE_LEN'(OP_JALR):    begin uses_alu = 1'b1; writes_rd = 1'b1; end
            OPCODE_LEN'(OP_BRANCH):  begin uses_alu = 1'b1; is_branch = 1'b1; end
            OPCODE_LEN'(OP_LOAD):    begin uses_alu = 1'b1; is_load = 1'b1; writes_rd = 1'b1; end
            OPCODE_LEN'(OP_STORE):   begin uses_alu = 1'b1; is_store = 1'b1; end
            OPCODE_LEN'(OP_ALU_IMM): begin uses_alu = 1'b1; writes_rd = 1'b1; end
            OPCODE_LEN'(OP_ALU_REG): begin uses_alu = 1'b1; writes_rd = 1'b1; end
            OPCODE_LEN'(OP_FENCE):   ;
            OPCODE_LEN'(OP_SYS):     ;
            default:                 legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// ----------------------------------------------------------------------------
// control_sequencer
// Moore sequencer that steps each accepted instruction through
// IDLE -> EXECUTE -> [MEM_WAIT] -> WRITEBACK, or into TRAP on an unknown
// opcode or a memory-ack timeout. All outputs are registered.
// Optional feature: define SEQ_PERF_COUNT_EN to build the retired-instruction
// counter; otherwise retired_count is tied to zero.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   instr_valid/instr_ready instruction handshake (ready only in IDLE)
//   opcode                  opcode, captured on handshake
//   mem_ack                 load/store completion (only looked at in MEM_WAIT)
//   enable_*                active-low unit enables
//   busy                    not in IDLE
//   illegal, timeout        one-cycle trap-cause pulses
//   retired_count           instructions completed through WRITEBACK
// ----------------------------------------------------------------------------
module control_sequencer
    import rv_ctrl_pkg::*;
#(
    parameter int OPCODE_LEN = 7,
    parameter int MAX_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [OPCODE_LEN-1:0] opcode,
    input  logic                  mem_ack,
    output logic                  enable_alu,
    output logic                  enable_branch,
    output logic                  enable_load,
    output logic                  enable_store,
    output logic                  enable_register_array,
    output logic                  enable_program_counter,
    output logic                  busy,
    output logic                  illegal,
    output logic                  timeout,
    output logic [31:0]           retired_count
);

    state_t                state;
    logic [OPCODE_LEN-1:0] op_q;
    logic [7:0]            wait_cnt;

    // In IDLE the incoming opcode is classified so EXECUTE's enables can be
    // registered on the handshake edge; afterwards only the captured copy is
    // used, so later changes on the opcode pins have no effect.
    logic [OPCODE_LEN-1:0] dec_op;
    logic legal, uses_alu, is_branch, is_load, is_store, writes_rd;

    assign dec_op = (state == IDLE) ? opcode : op_q;

    opcode_class_decode #(.OPCODE_LEN(OPCODE_LEN)) u_decode (
        .opcode    (dec_op),
        .legal     (legal),
        .uses_alu  (uses_alu),
        .is_branch (is_branch),
        .is_load   (is_load),
        .is_store  (is_store),
        .writes_rd (writes_rd)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                  <= IDLE;
            op_q                   <= '0;
            wait_cnt               <= '0;
            instr_ready            <= 1'b1;
            busy                   <= 1'b0;
            illegal                <= 1'b0;
            timeout                <= 1'b0;
            enable_alu             <= DISABLED;
            enable_branch          <= DISABLED;
            enable_load            <= DISABLED;
            enable_store           <= DISABLED;
            enable_register_array  <= DISABLED;
            enable_program_counter <= DISABLED;
        end else begin
            // Enables and pulses default off; each branch turns on only what
            // the state being entered needs.
            illegal                <= 1'b0;
            timeout                <= 1'b0;
            enable_alu             <= DISABLED;
            enable_branch          <= DISABLED;
            enable_load            <= DISABLED;
            enable_store           <= DISABLED;
            enable_register_array  <= DISABLED;
            enable_program_counter <= DISABLED;

            case (state)
                IDLE: begin
                    if (instr_valid && instr_ready) begin
                        op_q        <= opcode;
                        instr_ready <= 1'b0;
                        busy        <= 1'b1;
                        if (legal) begin
                            state         <= EXECUTE;
                            enable_alu    <= enable_if(uses_alu);
                            enable_branch <= enable_if(is_branch);
                        end else begin
                            state   <= TRAP;
                            illegal <= 1'b1;
                        end
                    end
                end

                EXECUTE: begin
                    if (is_load || is_store) begin
                        state        <= MEM_WAIT;
                        wait_cnt     <= '0;
                        enable_load  <= enable_if(is_load);
                        enable_store <= enable_if(is_store);
                    end else begin
                        state                  <= WRITEBACK;
                        enable_register_array  <= enable_if(writes_rd);
                        enable_program_counter <= ENABLED;
                    end
                end

                MEM_WAIT: begin
                    // Ack is checked first so it wins over the timeout limit.
                    if (mem_ack) begin
                        state                  <= WRITEBACK;
                        enable_register_array  <= enable_if(writes_rd);
                        enable_program_counter <= ENABLED;
                    end else if (wait_cnt == 8'(MAX_WAIT - 1)) begin
                        state   <= TRAP;
                        timeout <= 1'b1;
                    end else begin
                        wait_cnt     <= wait_cnt + 8'd1;
                        enable_load  <= enable_if(is_load);
                        enable_store <= enable_if(is_store);
                    end
                end

                WRITEBACK, TRAP: begin
                    state       <= IDLE;
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                end

                default: begin
                    state       <= IDLE;
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

`ifdef SEQ_PERF_COUNT_EN
    logic [31:0] retired_q;

    // One retire per WRITEBACK cycle; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else if (state == WRITEBACK) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign retired_count = retired_q;
`else
    assign retired_count = '0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// ----------------------------------------------------------------------------
// tb_control_sequencer
// Directed bench for control_sequencer (MAX_WAIT = 4). Enables are compared
// as a packed vector {alu, branch, load, store, register_array,
// program_counter} and handshake/status as {instr_ready, busy, illegal,
// timeout}. Outputs are sampled 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
module tb_control_sequencer;

    localparam int OPCODE_LEN = 7;
    localparam int MAX_WAIT   = 4;

    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_ALU_REG = 7'b0110011;
    localparam logic [6:0] OP_FENCE   = 7'b0001111;
    localparam logic [6:0] OP_BAD     = 7'b1111111;

    // Expected enable patterns (active-low), order {alu,br,ld,st,rf,pc}.
    localparam logic [5:0] EN_NONE   = 6'b111111;
    localparam logic [5:0] EN_ALU    = 6'b011111;
    localparam logic [5:0] EN_ALU_BR = 6'b001111;
    localparam logic [5:0] EN_LOAD   = 6'b110111;
    localparam logic [5:0] EN_STORE  = 6'b111011;
    localparam logic [5:0] EN_RF_PC  = 6'b111100;
    localparam logic [5:0] EN_PC     = 6'b111110;

    // Expected status patterns, order {ready,busy,illegal,timeout}.
    localparam logic [3:0] ST_IDLE  = 4'b1000;
    localparam logic [3:0] ST_BUSY  = 4'b0100;
    localparam logic [3:0] ST_ILL   = 4'b0110;
    localparam logic [3:0] ST_TMO   = 4'b0101;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  instr_valid = 1'b0;
    logic                  instr_ready;
    logic [OPCODE_LEN-1:0] opcode = '0;
    logic                  mem_ack = 1'b0;
    logic                  enable_alu, enable_branch, enable_load, enable_store;
    logic                  enable_register_array, enable_program_counter;
    logic                  busy, illegal, timeout;
    logic [31:0]           retired_count;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] model_count = '0;

    control_sequencer #(.OPCODE_LEN(OPCODE_LEN), .MAX_WAIT(MAX_WAIT)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .instr_valid            (instr_valid),
        .instr_ready            (instr_ready),
        .opcode                 (opcode),
        .mem_ack                (mem_ack),
        .enable_alu             (enable_alu),
        .enable_branch          (enable_branch),
        .enable_load            (enable_load),
        .enable_store           (enable_store),
        .enable_register_array  (enable_register_array),
        .enable_program_counter (enable_program_counter),
        .busy                   (busy),
        .illegal                (illegal),
        .timeout                (timeout),
        .retired_count          (retired_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] exp_rc();
`ifdef SEQ_PERF_COUNT_EN
        return model_count;
`else
        return 32'd0;
`endif
    endfunction

    task automatic expect_cycle(input string tag, input logic [5:0] en_exp, input logic [3:0] st_exp);
        check({tag, ".en"}, 32'({enable_alu, enable_branch, enable_load, enable_store,
                                 enable_register_array, enable_program_counter}), 32'(en_exp));
        check({tag, ".st"}, 32'({instr_ready, busy, illegal, timeout}), 32'(st_exp));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction for one edge; returns in the cycle after handshake.
    task automatic issue(input logic [6:0] op);
        opcode      = op;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
    endtask

    initial begin
        // Reset state, checked while reset is still asserted.
        #13;
        expect_cycle("reset", EN_NONE, ST_IDLE);
        check("reset.rc", retired_count, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        expect_cycle("post_reset", EN_NONE, ST_IDLE);

        // ALU_REG: EXECUTE, WRITEBACK, then ready again with one retire.
        issue(OP_ALU_REG);
        expect_cycle("alu.ex", EN_ALU, ST_BUSY);
        step();
        expect_cycle("alu.wb", EN_RF_PC, ST_BUSY);
        step();
        model_count++;
        expect_cycle("alu.idle", EN_NONE, ST_IDLE);
        check("alu.rc", retired_count, exp_rc());

        // LOAD with ack in the third MEM_WAIT cycle.
        issue(OP_LOAD);
        expect_cycle("ld.ex", EN_ALU, ST_BUSY);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_cycle($sformatf("ld.mw%0d", i), EN_LOAD, ST_BUSY);
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        expect_cycle("ld.wb", EN_RF_PC, ST_BUSY);
        step();
        model_count++;
        expect_cycle("ld.idle", EN_NONE, ST_IDLE);
        check("ld.rc", retired_count, exp_rc());

        // STORE without ack: 4 MEM_WAIT cycles then TRAP with timeout.
        // Opcode pins change after capture and must be ignored.
        issue(OP_STORE);
        opcode = OP_LOAD;
        expect_cycle("st.ex", EN_ALU, ST_BUSY);
        for (int i = 0; i < MAX_WAIT; i++) begin
            step();
            expect_cycle($sformatf("st.mw%0d", i), EN_STORE, ST_BUSY);
        end
        step();
        expect_cycle("st.trap", EN_NONE, ST_TMO);
        step();
        expect_cycle("st.idle", EN_NONE, ST_IDLE);
        check("st.rc", retired_count, exp_rc());

        // LOAD with ack arriving exactly at the timeout limit: ack wins.
        issue(OP_LOAD);
        for (int i = 0; i < MAX_WAIT; i++) step();
        expect_cycle("ldlim.mw_last", EN_LOAD, ST_BUSY);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        expect_cycle("ldlim.wb", EN_RF_PC, ST_BUSY);
        step();
        model_count++;
        check("ldlim.rc", retired_count, exp_rc());

        // Unknown opcode: TRAP next cycle with a one-cycle illegal pulse.
        issue(OP_BAD);
        expect_cycle("ill.trap", EN_NONE, ST_ILL);
        step();
        expect_cycle("ill.idle", EN_NONE, ST_IDLE);
        check("ill.rc", retired_count, exp_rc());

        // BRANCH then FENCE back-to-back.
        issue(OP_BRANCH);
        expect_cycle("br.ex", EN_ALU_BR, ST_BUSY);
        step();
        expect_cycle("br.wb", EN_PC, ST_BUSY);
        step();
        model_count++;
        expect_cycle("br.idle", EN_NONE, ST_IDLE);
        issue(OP_FENCE);
        expect_cycle("fence.ex", EN_NONE, ST_BUSY);
        step();
        expect_cycle("fence.wb", EN_PC, ST_BUSY);
        step();
        model_count++;
        expect_cycle("fence.idle", EN_NONE, ST_IDLE);
        check("fence.rc", retired_count, exp_rc());

        // Asynchronous reset in MEM_WAIT, away from any clock edge.
        issue(OP_LOAD);
        step();
        expect_cycle("rst.mw", EN_LOAD, ST_BUSY);
        #2;
        rst_n = 1'b0;
        #1;
        expect_cycle("rst.async", EN_NONE, ST_IDLE);
        check("rst.rc", retired_count, 32'd0);
        model_count = '0;
        mem_ack = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        expect_cycle("rst.ack_ignored", EN_NONE, ST_IDLE);
        step();
        mem_ack = 1'b0;
        expect_cycle("rst.still_idle", EN_NONE, ST_IDLE);
        check("rst.rc_after", retired_count, exp_rc());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter OPCODE_LEN, default 7, opcode field width.
REQ-002 SHALL have parameter MAX_WAIT, default 15, memory-ack timeout in cycles (1..255).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 instr_valid  in  1  upstream has an instruction.
REQ-006 instr_ready  out  1  sequencer accepts an instruction; high only in IDLE.
REQ-007 opcode  in  OPCODE_LEN  opcode; captured on instr_valid && instr_ready.
REQ-008 mem_ack  in  1  memory completion for load/store.
REQ-009 enable_alu, enable_branch, enable_load, enable_store, enable_register_array, enable_program_counter  out  1 each  unit enables, active-low: ENABLED=0, DISABLED=1.
REQ-010 busy  out  1  high in any state other than IDLE.
REQ-011 illegal  out  1  one-cycle pulse on an unknown opcode.
REQ-012 timeout  out  1  one-cycle pulse on memory timeout.
REQ-013 retired_count  out  32  retired-instruction count (see Configuration).

Function
REQ-014 SHALL implement states IDLE, EXECUTE, MEM_WAIT, WRITEBACK, TRAP; all outputs are registered or decoded from state and the captured opcode only (Moore).
REQ-015 Legal opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, ALU_IMM 0010011, ALU_REG 0110011, FENCE 0001111, SYS 1110011.
REQ-016 IDLE: on handshake, capture opcode; a legal opcode goes to EXECUTE, any other goes to TRAP.
REQ-017 EXECUTE (1 cycle): enable_alu ENABLED for AUIPC/JAL/JALR/BRANCH/LOAD/STORE/ALU_IMM/ALU_REG; enable_branch ENABLED for BRANCH; next state is MEM_WAIT for LOAD/STORE, else WRITEBACK.
REQ-018 MEM_WAIT: enable_load (LOAD) or enable_store (STORE) held ENABLED; 8-bit wait counter cleared on entry, +1 per cycle without mem_ack.
REQ-019 MEM_WAIT exit: mem_ack=1 goes to WRITEBACK; counter==MAX_WAIT-1 with mem_ack=0 goes to TRAP; if mem_ack and the limit coincide, mem_ack wins.
REQ-020 WRITEBACK (1 cycle): enable_register_array ENABLED for LUI/AUIPC/JAL/JALR/LOAD/ALU_IMM/ALU_REG; enable_program_counter ENABLED for every legal opcode; next state IDLE.
REQ-021 TRAP (1 cycle): all enables DISABLED; illegal or timeout pulses according to cause; next state IDLE; no retire.
REQ-022 Every enable not named for the current state SHALL be DISABLED.
REQ-023 Latency, handshake at cycle N: non-memory ops have EXECUTE at N+1, WRITEBACK at N+2, instr_ready high at N+3. Memory ops: ack sampled at cycle M gives WRITEBACK at M+1.
REQ-024 mem_ack outside MEM_WAIT SHALL be ignored; opcode changes after capture SHALL be ignored.

Reset
REQ-025 Asserting rst_n=0 at any time, including mid-instruction, SHALL force IDLE, all enables DISABLED, busy=0, illegal=0, timeout=0, wait counter=0, retired_count=0, with no pulse emitted.
REQ-026 After reset release, instr_ready=1 in the first cycle.

Configuration
REQ-027 Macro SEQ_PERF_COUNT_EN defined: retired_count increments by 1 in each WRITEBACK cycle and wraps from 0xFFFFFFFF to 0.
REQ-028 Macro SEQ_PERF_COUNT_EN undefined: the counter is not built; retired_count is tied to 0; the port remains.

Structure
REQ-029 Package rv_ctrl_pkg SHALL hold the opcode constants, the ENABLED/DISABLED constants and the state enum typedef.
REQ-030 Sub-module opcode_class_decode (combinational) SHALL map opcode to legal, uses_alu, is_branch, is_load, is_store, writes_rd.

Verification
REQ-031 ALU_REG 0110011 accepted at cycle 0: enable_alu=0 at cycle 1; enable_register_array=0 and enable_program_counter=0 at cycle 2; instr_ready=1 at cycle 3; retired_count=1 (macro defined).
REQ-032 LOAD, mem_ack at the 3rd MEM_WAIT cycle: enable_load=0 for 3 cycles, then WRITEBACK with enable_register_array=0.
REQ-033 STORE with mem_ack held 0, MAX_WAIT=4: TRAP after 4 MEM_WAIT cycles, timeout=1 for 1 cycle, no register or PC enable, retired_count unchanged.
REQ-034 Opcode 1111111: TRAP the next cycle, illegal=1 for 1 cycle, all enables stay 1.
REQ-035 rst_n=0 asynchronously during MEM_WAIT: outputs reach their reset values without a clock edge; a subsequent mem_ack is ignored.
REQ-036 BRANCH then FENCE back-to-back: BRANCH asserts alu+branch in EXECUTE; FENCE asserts only enable_program_counter in WRITEBACK; retired_count=2.
